// File: rtl/uart_rx_frame_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_frame_if : received-frame valid/ready channel with status flags
// Rev 1.0
// ----------------------------------------------------------------------------
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 brk;

  modport master (
    output m_data, m_valid, parity_err, frame_err, brk,
    input  m_ready
  );

  modport slave (
    input  m_data, m_valid, parity_err, frame_err, brk,
    output m_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_frame : parametrised UART receiver with parity/framing/break status
//                 and a valid/ready holding register with overrun reporting.
// Optional macro UART_RX_MAJORITY_EN : 2-of-3 majority vote per bit decision.
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_rx_frame #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9_600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rxsig,
  uart_rx_frame_if.master m_if,
  output logic            overrun,
  output logic            busy
);
  localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int IDX_W        = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC_AT       = HALF + 1;
`else
  localparam int DEC_AT       = HALF;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DEC_CNT   = CNT_W'(DEC_AT);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [1:0]             prime_q, prime_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d, ferr_q, ferr_d, any1_q, any1_d;
  logic [DATA_BITS-1:0]   m_data_q, m_data_d;
  logic                   m_valid_q, m_valid_d, perr_q, perr_d;
  logic                   ferr_out_q, ferr_out_d, brk_q, brk_d;
  logic                   overrun_q, overrun_d;
  logic                   rx_s, decide, bit_val, done, fr_ferr, fr_brk, fr_perr;

  assign rx_s   = sync2_q;
  assign decide = (cnt_q == DEC_CNT);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] SMP_A = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] SMP_B = CNT_W'(HALF);
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (cnt_q == SMP_A) hist_d[0] = rx_s;
    if (cnt_q == SMP_B) hist_d[1] = rx_s;
  end

  always_ff @(posedge clk) begin
    if (rst) hist_q <= 2'b11;
    else     hist_q <= hist_d;
  end

  assign bit_val = (hist_q[0] & hist_q[1]) | (hist_q[0] & rx_s) | (hist_q[1] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  // prev is only trusted once the reset value of the synchroniser has flushed,
  // so a line held low through reset cannot look like a falling edge.
  always_comb begin
    sync1_d = rxsig;
    sync2_d = sync1_q;
    prime_d = {prime_q[0], 1'b1};
    prev_d  = prime_q[1] ? rx_s : 1'b0;
  end

  assign fr_perr = (PARITY != 0) && ((^shift_q ^ par_q) != (PARITY == 2));

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    ferr_d  = ferr_q;
    any1_d  = any1_q;
    done    = 1'b0;
    fr_ferr = ferr_q | ~bit_val;
    fr_brk  = ~(any1_q | bit_val);
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        ferr_d = 1'b0;
        any1_d = 1'b0;
        if (prev_q && !rx_s) state_d = S_START;
      end
      // The baud counter keeps running after the start check, so every later
      // decision lands at the same offset into its own bit period.
      S_START: begin
        if (decide) state_d = bit_val ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (decide) begin
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          any1_d  = any1_q | bit_val;
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (decide) begin
          par_d   = bit_val;
          any1_d  = any1_q | bit_val;
          idx_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (decide) begin
          ferr_d = fr_ferr;
          any1_d = any1_q | bit_val;
          if (idx_q == LAST_STOP) begin
            done    = 1'b1;
            state_d = fr_brk ? S_BRK_WAIT : S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_BRK_WAIT: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    perr_d     = perr_q;
    ferr_out_d = ferr_out_q;
    brk_d      = brk_q;
    overrun_d  = 1'b0;
    if (done) begin
      if (!m_valid_q || m_if.m_ready) begin
        m_data_d   = shift_q;
        m_valid_d  = 1'b1;
        perr_d     = fr_perr;
        ferr_out_d = fr_ferr;
        brk_d      = fr_brk;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (m_valid_q && m_if.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b0;
      prime_q    <= 2'b00;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ferr_q     <= 1'b0;
      any1_q     <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_out_q <= 1'b0;
      brk_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      prime_q    <= prime_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ferr_q     <= ferr_d;
      any1_q     <= any1_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      perr_q     <= perr_d;
      ferr_out_q <= ferr_out_d;
      brk_q      <= brk_d;
      overrun_q  <= overrun_d;
    end
  end

  assign m_if.m_data     = m_data_q;
  assign m_if.m_valid    = m_valid_q;
  assign m_if.parity_err = perr_q;
  assign m_if.frame_err  = ferr_out_q;
  assign m_if.brk        = brk_q;
  assign overrun         = overrun_q;
  assign busy            = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_rx_frame : self-checking bench, two receiver configurations
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_rx_frame;
  localparam int CPB = 10;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic ovr_a, busy_a, ovr_b, busy_b;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ovr_cnt_a = 0;
  rec_t q_a[$];
  rec_t q_b[$];

  uart_rx_frame_if #(.DATA_BITS(8)) if_a ();
  uart_rx_frame_if #(.DATA_BITS(7)) if_b ();

  uart_rx_frame #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                  .PARITY(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .rxsig(rx_a), .m_if(if_a), .overrun(ovr_a), .busy(busy_a));

  uart_rx_frame #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                  .PARITY(0), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .rxsig(rx_b), .m_if(if_b), .overrun(ovr_b), .busy(busy_b));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (if_a.m_valid && if_a.m_ready)
        q_a.push_back(rec_t'({1'b0, if_a.m_data, if_a.parity_err, if_a.frame_err, if_a.brk}));
      if (if_b.m_valid && if_b.m_ready)
        q_b.push_back(rec_t'({2'b00, if_b.m_data, if_b.parity_err, if_b.frame_err, if_b.brk}));
      if (ovr_a) ovr_cnt_a++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  // Start bit, then nb bits LSB first, then the line returns high.
  task automatic send_line(input int sel, input logic [15:0] bits, input int nb, input int idle);
    set_rx(sel, 1'b0);
    tick(CPB);
    for (int i = 0; i < nb; i++) begin
      set_rx(sel, bits[i]);
      tick(CPB);
    end
    set_rx(sel, 1'b1);
    tick(idle);
  endtask

  // Reference: what the frame means, derived from the bit values on the line.
  function automatic rec_t model(input logic [8:0] data, input int pmode, input logic pbit,
                                 input logic [1:0] stops, input int nstop);
    rec_t r;
    int   ones;
    ones = $countones(data) + ((pmode != 0) ? int'(pbit) : 0);
    r.d  = data;
    r.pe = (pmode == 0) ? 1'b0 : ((ones % 2) != ((pmode == 2) ? 1 : 0));
    r.fe = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
    r.bk = (ones == 0) && (stops[0] == 1'b0) && (nstop == 1 || stops[1] == 1'b0);
    return r;
  endfunction

  task automatic test_reset();
    rx_a = 1'b0;
    rst  = 1'b1;
    tick(4);
    n_cmp++;
    if ({if_a.m_data, if_a.m_valid, if_a.parity_err, if_a.frame_err, if_a.brk, ovr_a, busy_a} !== '0) begin
      n_bad++;
      $display("FAIL reset_a: got data=%h v=%b pe=%b fe=%b bk=%b ovr=%b busy=%b, want all 0",
               if_a.m_data, if_a.m_valid, if_a.parity_err, if_a.frame_err, if_a.brk, ovr_a, busy_a);
    end
    n_cmp++;
    if ({if_b.m_data, if_b.m_valid, if_b.parity_err, if_b.frame_err, if_b.brk, ovr_b, busy_b} !== '0) begin
      n_bad++;
      $display("FAIL reset_b: got data=%h v=%b busy=%b, want all 0", if_b.m_data, if_b.m_valid, busy_b);
    end
    rst = 1'b0;
    tick(2 * CPB);
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL low_after_reset: busy=%b, want 0 (level-low line must not start a frame)", busy_a);
    end
    rx_a = 1'b1;
    tick(5);
  endtask

  task automatic test_good_and_parity();
    rec_t exp, got;
    send_line(0, {6'b0, 1'b1, 1'b0, 8'hA5}, 10, 3);
    exp = model(9'h0A5, 1, 1'b0, 2'b01, 1);
    got = (q_a.size() > 0) ? q_a.pop_front() : 'x;
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL good_a5: got %h, want %h", got, exp);
    end
    send_line(0, {6'b0, 1'b1, 1'b1, 8'hA5}, 10, 3);
    exp = model(9'h0A5, 1, 1'b1, 2'b01, 1);
    got = (q_a.size() > 0) ? q_a.pop_front() : 'x;
    n_cmp++;
    if (got !== exp || exp.pe !== 1'b1) begin
      n_bad++;
      $display("FAIL parity_a5: got %h, want %h", got, exp);
    end
  endtask

  task automatic test_frame_err();
    rec_t exp, got;
    send_line(0, {6'b0, 1'b0, 1'b0, 8'h3C}, 10, 2 * CPB);
    exp = model(9'h03C, 1, 1'b0, 2'b00, 1);
    got = (q_a.size() > 0) ? q_a.pop_front() : 'x;
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL frame_err_3c: got %h, want %h", got, exp);
    end
    send_line(0, {6'b0, 1'b1, 1'b0, 8'h5A}, 10, 3);
    exp = model(9'h05A, 1, 1'b0, 2'b01, 1);
    got = (q_a.size() > 0) ? q_a.pop_front() : 'x;
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL after_ferr_5a: got %h, want %h", got, exp);
    end
  endtask

  task automatic test_glitch_and_reset();
    bit saw_busy = 0;
    rx_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      saw_busy |= busy_a;
    end
    rx_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      saw_busy |= busy_a;
    end
    n_cmp++;
    if (saw_busy !== 1'b1 || busy_a !== 1'b0 || q_a.size() != 0) begin
      n_bad++;
      $display("FAIL glitch: saw_busy=%b busy=%b frames=%0d, want 1/0/0", saw_busy, busy_a, q_a.size());
    end
    // all-zero payload with even parity bit 0: line stays low after reset
    rx_a = 1'b0;
    tick(4 * CPB);
    rst = 1'b1;
    tick(1);
    n_cmp++;
    if (busy_a !== 1'b0 || if_a.m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_midframe: busy=%b valid=%b, want 0/0", busy_a, if_a.m_valid);
    end
    rst = 1'b0;
    tick(6 * CPB);
    rx_a = 1'b1;
    tick(3 * CPB);
    n_cmp++;
    if (q_a.size() != 0 || busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_discard: frames=%0d busy=%b, want 0/0", q_a.size(), busy_a);
    end
  endtask

  task automatic test_overrun();
    rec_t got;
    if_a.m_ready = 1'b0;
    send_line(0, {6'b0, 1'b1, 1'b0, 8'h11}, 10, 0);
    send_line(0, {6'b0, 1'b1, 1'b0, 8'h22}, 10, 5);
    n_cmp++;
    if (if_a.m_valid !== 1'b1 || if_a.m_data !== 8'h11 || if_a.parity_err !== 1'b0 || q_a.size() != 0) begin
      n_bad++;
      $display("FAIL overrun_hold: valid=%b data=%h pe=%b, want 1/11/0", if_a.m_valid, if_a.m_data, if_a.parity_err);
    end
    n_cmp++;
    if (ovr_cnt_a != 1) begin
      n_bad++;
      $display("FAIL overrun_pulse: cycles=%0d, want 1", ovr_cnt_a);
    end
    if_a.m_ready = 1'b1;
    tick(1);
    got = (q_a.size() > 0) ? q_a.pop_front() : 'x;
    n_cmp++;
    if (got !== model(9'h011, 1, 1'b0, 2'b01, 1) || if_a.m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_drain: got %h valid=%b, want %h valid=0", got, if_a.m_valid,
               model(9'h011, 1, 1'b0, 2'b01, 1));
    end
  endtask

  task automatic test_break();
    rec_t got;
    rx_a = 1'b0;
    tick(14 * CPB);
    n_cmp++;
    if (busy_a !== 1'b1 || q_a.size() != 1) begin
      n_bad++;
      $display("FAIL brk_hold: busy=%b frames=%0d, want 1/1", busy_a, q_a.size());
    end
    tick(CPB);
    rx_a = 1'b1;
    tick(5);
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_bad++;
      $display("FAIL brk_release: busy=%b, want 0", busy_a);
    end
    got = (q_a.size() > 0) ? q_a.pop_front() : 'x;
    n_cmp++;
    if (got !== model(9'h000, 1, 1'b0, 2'b00, 1)) begin
      n_bad++;
      $display("FAIL brk_frame: got %h, want %h", got, model(9'h000, 1, 1'b0, 2'b00, 1));
    end
    tick(3 * CPB);
    n_cmp++;
    if (q_a.size() != 0) begin
      n_bad++;
      $display("FAIL brk_no_second: frames=%0d, want 0", q_a.size());
    end
  endtask

  task automatic test_random_a();
    rec_t exp, got;
    logic [7:0] data;
    logic pbit, stop;
    for (int k = 0; k < 10; k++) begin
      data = 8'($urandom_range(0, 255));
      pbit = ($urandom_range(0, 3) == 0) ? ~(^data) : (^data);
      stop = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      send_line(0, {6'b0, stop, pbit, data}, 10, 3);
      exp = model({1'b0, data}, 1, pbit, {1'b1, stop}, 1);
      got = (q_a.size() > 0) ? q_a.pop_front() : 'x;
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL random_a[%0d]: data=%h p=%b s=%b got %h, want %h", k, data, pbit, stop, got, exp);
      end
    end
  endtask

  task automatic test_cfg_b();
    rec_t exp, got;
    logic [6:0] data;
    logic [1:0] stops;
    send_line(1, {7'b0, 2'b11, 7'h55}, 9, 3);
    got = (q_b.size() > 0) ? q_b.pop_front() : 'x;
    n_cmp++;
    if (got !== model(9'h055, 0, 1'b0, 2'b11, 2)) begin
      n_bad++;
      $display("FAIL cfg_b_55: got %h, want %h", got, model(9'h055, 0, 1'b0, 2'b11, 2));
    end
    for (int k = 0; k < 6; k++) begin
      data  = 7'($urandom_range(1, 127));
      stops = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      send_line(1, {7'b0, stops, data}, 9, 3);
      exp = model({2'b0, data}, 0, 1'b0, stops, 2);
      got = (q_b.size() > 0) ? q_b.pop_front() : 'x;
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL random_b[%0d]: data=%h stops=%b got %h, want %h", k, data, stops, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    rec_t got;
    logic [7:0] d0, d1;
    d0 = 8'($urandom_range(0, 255));
    d1 = 8'($urandom_range(0, 255));
    send_line(0, {6'b0, 1'b1, ^d0, d0}, 10, 0);
    send_line(0, {6'b0, 1'b1, ^d1, d1}, 10, 3);
    n_cmp++;
    if (q_a.size() != 2) begin
      n_bad++;
      $display("FAIL b2b_count: frames=%0d, want 2", q_a.size());
    end else begin
      got = q_a.pop_front();
      n_cmp++;
      if (got !== model({1'b0, d0}, 1, ^d0, 2'b01, 1)) begin
        n_bad++;
        $display("FAIL b2b_first: got %h, want %h", got, model({1'b0, d0}, 1, ^d0, 2'b01, 1));
      end
      got = q_a.pop_front();
      n_cmp++;
      if (got !== model({1'b0, d1}, 1, ^d1, 2'b01, 1)) begin
        n_bad++;
        $display("FAIL b2b_second: got %h, want %h", got, model({1'b0, d1}, 1, ^d1, 2'b01, 1));
      end
    end
  endtask

  initial begin
    if_a.m_ready = 1'b1;
    if_b.m_ready = 1'b1;
    test_reset();
    test_good_and_parity();
    test_frame_err();
    test_glitch_and_reset();
    test_overrun();
    test_break();
    test_random_a();
    test_back_to_back();
    test_cfg_b();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
